// File: rtl/taiga_hpm_counter_bank.sv
// Bank of NUM_COUNTERS performance counters for the Taiga core. Each counter has
// its own event selection, wrap/saturate mode, sticky overflow and interrupt enable.
module taiga_hpm_counter_bank #(
   parameter int NUM_COUNTERS = 4,
   parameter int COUNTER_W    = 33,
   parameter int NUM_EVENTS   = 16,
   parameter int EVENT_SEL_W  = $clog2(NUM_EVENTS),
   parameter int ADDR_W       = $clog2(NUM_COUNTERS) + 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_EVENTS-1:0]   events,
   input  logic                    freeze,
   input  logic                    csr_req,
   input  logic                    csr_we,
   input  logic [ADDR_W-1:0]       csr_addr,
   input  logic [31:0]             csr_wdata,
   output logic [31:0]             csr_rdata,
   output logic                    csr_rvalid,
   output logic [NUM_COUNTERS-1:0] ovf_irq
);

   localparam int HI_W  = COUNTER_W - 32;
   localparam int IDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

   localparam logic [1:0] REG_LO     = 2'd0;
   localparam logic [1:0] REG_HI     = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   logic [IDX_W-1:0] idx;
   logic [1:0]       reg_sel;
   logic             idx_ok;
   logic             wr_acc;
   logic             rd_acc;

   logic [COUNTER_W-1:0]    cnt       [NUM_COUNTERS];
   logic [HI_W-1:0]         hi_shadow [NUM_COUNTERS];
   logic [31:0]             ctrl_rd   [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] ovf;
   logic [NUM_COUNTERS-1:0] irq_en;

   logic [31:0] rd_next;
   logic [31:0] rdata_p1;
   logic        rvld_p1;

   generate
      if (ADDR_W > 2) begin : g_idx
         assign idx = csr_addr[ADDR_W-1:2];
      end else begin : g_idx_single
         assign idx = '0;
      end
   endgenerate

   assign reg_sel = csr_addr[1:0];
   assign idx_ok  = (32'(idx) < NUM_COUNTERS);
   assign wr_acc  = csr_req & csr_we & idx_ok;
   assign rd_acc  = csr_req & ~csr_we;

   for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
      logic                   hit;
      logic                   lo_wr, hi_wr, ctrl_wr, stat_wr, lo_rd;
      logic [EVENT_SEL_W-1:0] sel;
      logic                   en, sat, ie, ov;
      logic [COUNTER_W-1:0]   c;
      logic [HI_W-1:0]        sh;
      logic                   ev_hit, inc, at_max, ovf_set;

      assign hit     = (idx == IDX_W'(i));
      assign lo_wr   = wr_acc & hit & (reg_sel == REG_LO);
      assign hi_wr   = wr_acc & hit & (reg_sel == REG_HI);
      assign ctrl_wr = wr_acc & hit & (reg_sel == REG_CTRL);
      assign stat_wr = wr_acc & hit & (reg_sel == REG_STATUS);
      assign lo_rd   = rd_acc & hit & (reg_sel == REG_LO);

      // Out-of-range selects behave as a permanently idle event.
      always_comb begin
         ev_hit = 1'b0;
         if (32'(sel) < NUM_EVENTS) ev_hit = events[sel];
      end

      assign inc     = en & ~freeze & ev_hit;
      assign at_max  = &c;
      assign ovf_set = inc & at_max & ~(lo_wr | hi_wr);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            c   <= '0;
            sh  <= '0;
            sel <= '0;
            en  <= 1'b0;
            sat <= 1'b0;
            ie  <= 1'b0;
            ov  <= 1'b0;
         end else begin
            if (lo_wr) c[31:0] <= csr_wdata;
            if (hi_wr) c[COUNTER_W-1:32] <= csr_wdata[HI_W-1:0];
            // A software write to either half drops this cycle's increment.
            if (inc && !lo_wr && !hi_wr && !(at_max && sat)) c <= c + 1'b1;
            if (ctrl_wr) begin
               en  <= csr_wdata[31];
               sat <= csr_wdata[30];
               ie  <= csr_wdata[29];
               sel <= csr_wdata[EVENT_SEL_W-1:0];
            end
            ov <= ovf_set | (ov & ~(stat_wr & csr_wdata[0]));
            if (lo_rd) sh <= c[COUNTER_W-1:32];
         end
      end

      always_comb begin
         ctrl_rd[i]                  = '0;
         ctrl_rd[i][31]              = en;
         ctrl_rd[i][30]              = sat;
         ctrl_rd[i][29]              = ie;
         ctrl_rd[i][EVENT_SEL_W-1:0] = sel;
      end

      assign cnt[i]       = c;
      assign hi_shadow[i] = sh;
      assign ovf[i]       = ov;
      assign irq_en[i]    = ie;
   end

   always_comb begin
      rd_next = '0;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         if (idx == IDX_W'(k)) begin
            case (reg_sel)
               REG_LO:     rd_next = cnt[k][31:0];
               REG_HI:     rd_next = 32'(hi_shadow[k]);
               REG_CTRL:   rd_next = ctrl_rd[k];
               REG_STATUS: rd_next = {31'b0, ovf[k]};
               default:    rd_next = '0;
            endcase
         end
      end
   end

   // p1: registered read response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvld_p1  <= 1'b0;
         rdata_p1 <= '0;
      end else begin
         rvld_p1 <= rd_acc;
         if (rd_acc) rdata_p1 <= rd_next;
      end
   end

   assign csr_rvalid = rvld_p1;
   assign csr_rdata  = rdata_p1;
   assign ovf_irq    = ovf & irq_en;

endmodule

// File: tb/tb_taiga_hpm_counter_bank.sv
// Directed bench for taiga_hpm_counter_bank: 4 counters of 33 bits, 12 events so
// that an out-of-range event select is representable.
module tb_taiga_hpm_counter_bank;

   localparam int NC  = 4;
   localparam int CW  = 33;
   localparam int NE  = 12;
   localparam int ESW = $clog2(NE);
   localparam int AW  = $clog2(NC) + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NE-1:0] events;
   logic          freeze;
   logic          csr_req;
   logic          csr_we;
   logic [AW-1:0] csr_addr;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_rdata;
   logic          csr_rvalid;
   logic [NC-1:0] ovf_irq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] b2b_exp [4];

   taiga_hpm_counter_bank #(
      .NUM_COUNTERS(NC), .COUNTER_W(CW), .NUM_EVENTS(NE),
      .EVENT_SEL_W(ESW), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .events(events), .freeze(freeze),
      .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
      .ovf_irq(ovf_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input int r, input logic [31:0] d);
      csr_req   = 1'b1;
      csr_we    = 1'b1;
      csr_addr  = AW'((idx << 2) | r);
      csr_wdata = d;
      tick();
      csr_req = 1'b0;
      csr_we  = 1'b0;
   endtask

   task automatic rd(input int idx, input int r, input logic [31:0] exp, input string tag);
      csr_req  = 1'b1;
      csr_we   = 1'b0;
      csr_addr = AW'((idx << 2) | r);
      tick();
      csr_req = 1'b0;
      check({tag, "_vld"}, 64'(csr_rvalid), 64'd1);
      check(tag, 64'(csr_rdata), 64'(exp));
   endtask

   initial begin
      rst_n = 1'b0; events = '0; freeze = 1'b0;
      csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
      repeat (2) tick();
      check("rst_rvalid", 64'(csr_rvalid), 64'd0);
      check("rst_rdata", 64'(csr_rdata), 64'd0);
      check("rst_irq", 64'(ovf_irq), 64'd0);
      rst_n = 1'b1;
      tick();

      // Every register of every counter reads 0; response exactly one cycle after request.
      for (int i = 0; i < NC; i++) begin
         for (int r = 0; r < 4; r++) begin
            rd(i, r, 32'h0, $sformatf("rst_c%0d_r%0d", i, r));
            tick();
            check($sformatf("idle_c%0d_r%0d", i, r), 64'(csr_rvalid), 64'd0);
         end
      end

      // Ten event cycles on event 3, three of them frozen.
      wr(0, 2, 32'h8000_0003);
      rd(0, 2, 32'h8000_0003, "ctrl0");
      events[3] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         freeze = (c >= 4 && c < 7);
         tick();
      end
      events = '0; freeze = 1'b0;
      rd(0, 0, 32'd7, "count7");

      // Select equal to NUM_EVENTS never counts.
      wr(0, 2, 32'h8000_000C);
      rd(0, 2, 32'h8000_000C, "ctrl_oor");
      events = '1;
      repeat (5) tick();
      events = '0;
      rd(0, 0, 32'd7, "sel_oor_hold");

      // Unimplemented CTRL bits read as zero.
      wr(1, 2, 32'hFFFF_FFFF);
      rd(1, 2, 32'hE000_000F, "ctrl_mask");
      wr(1, 2, 32'h0);

      // Wrap mode overflow with interrupt, then W1C.
      wr(2, 0, 32'hFFFF_FFFF);
      wr(2, 1, 32'hFFFF_FFFF);
      wr(2, 2, 32'hA000_0005);
      check("irq_pre_wrap", 64'(ovf_irq), 64'd0);
      events[5] = 1'b1;
      tick();
      events = '0;
      check("irq_wrap", 64'(ovf_irq), 64'h4);
      rd(2, 0, 32'h0, "wrap_lo");
      rd(2, 1, 32'h0, "wrap_hi");
      rd(2, 3, 32'h1, "wrap_ovf");
      wr(2, 3, 32'h1);
      check("irq_clear", 64'(ovf_irq), 64'd0);
      rd(2, 3, 32'h0, "wrap_ovf_clr");

      // Saturate mode; HI write drops bits above the counter width.
      wr(3, 0, 32'hFFFF_FFFF);
      wr(3, 1, 32'h0000_0003);
      wr(3, 2, 32'hE000_0006);
      events[6] = 1'b1;
      repeat (2) tick();
      check("irq_sat", 64'(ovf_irq), 64'h8);
      wr(3, 3, 32'h1);
      events = '0;
      check("irq_set_wins", 64'(ovf_irq), 64'h8);
      rd(3, 0, 32'hFFFF_FFFF, "sat_lo");
      rd(3, 1, 32'h1, "sat_hi");
      rd(3, 3, 32'h1, "sat_ovf");
      wr(3, 3, 32'h1);
      rd(3, 3, 32'h0, "sat_ovf_clr");

      // Tear-free LO/HI pair while the counter crosses the 32-bit boundary.
      wr(0, 1, 32'h0);
      wr(0, 2, 32'h8000_0003);
      events[3] = 1'b1;
      wr(0, 0, 32'hFFFF_FFFF);
      rd(0, 0, 32'hFFFF_FFFF, "tear_lo");
      tick();
      rd(0, 1, 32'h0, "tear_hi");
      events = '0;
      rd(0, 0, 32'h2, "live_lo");
      rd(0, 1, 32'h1, "live_hi");

      // Write beats a simultaneous increment.
      events[3] = 1'b1;
      wr(0, 0, 32'd5);
      events = '0;
      rd(0, 0, 32'd5, "wr_wins");

      // Register access works while frozen.
      freeze = 1'b1;
      wr(1, 0, 32'h1234);
      rd(1, 0, 32'h1234, "freeze_acc");
      freeze = 1'b0;

      // Back-to-back LO reads of all counters.
      b2b_exp[0] = 32'd5;
      b2b_exp[1] = 32'h1234;
      b2b_exp[2] = 32'h0;
      b2b_exp[3] = 32'hFFFF_FFFF;
      for (int k = 0; k < NC; k++) begin
         csr_req  = 1'b1;
         csr_we   = 1'b0;
         csr_addr = AW'(k << 2);
         tick();
         check($sformatf("b2b%0d_vld", k), 64'(csr_rvalid), 64'd1);
         check($sformatf("b2b%0d", k), 64'(csr_rdata), 64'(b2b_exp[k]));
      end
      csr_req = 1'b0;
      tick();
      check("b2b_end_vld", 64'(csr_rvalid), 64'd0);

      // Reset while a response and an interrupt are live.
      events[6] = 1'b1;
      tick();
      events = '0;
      check("irq_before_rst", 64'(ovf_irq), 64'h8);
      csr_req  = 1'b1;
      csr_addr = AW'(3 << 2);
      tick();
      csr_req = 1'b0;
      check("pre_rst_vld", 64'(csr_rvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", 64'(csr_rvalid), 64'd0);
      check("mid_rst_rdata", 64'(csr_rdata), 64'd0);
      check("mid_rst_irq", 64'(ovf_irq), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", 64'(csr_rvalid), 64'd0);
      rd(3, 0, 32'h0, "post_rst_lo");
      rd(3, 2, 32'h0, "post_rst_ctrl");
      rd(3, 3, 32'h0, "post_rst_ovf");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/taiga_hpm_counter_bank.md
# taiga_hpm_counter_bank

Parametrised hardware performance-monitor counter bank for the Taiga core. It generalises the single fixed-width CSR cycle/instret counter into NUM_COUNTERS independent counters, each COUNTER_W bits wide, with runtime event selection, wrap or saturate mode, sticky overflow and per-counter interrupt. The bank sits beside the CSR unit in the GC path; the CSR unit drives its 32-bit register port, and pipeline/memory units drive its event pulse vector.

## Interface
- NUM_COUNTERS, 4, number of counters (1..32)
- COUNTER_W, 33, counter width in bits (33..64)
- NUM_EVENTS, 16, width of event input vector (2..256)
- EVENT_SEL_W, $clog2(NUM_EVENTS), width of the event-select field
- ADDR_W, $clog2(NUM_COUNTERS)+2, register address width
---
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- events  in  NUM_EVENTS  event-occurred-this-cycle pulses, one bit per event
- freeze  in  1  global inhibit (debug halt); no counter increments while high
- csr_req  in  1  register access strobe, one access per cycle
- csr_we  in  1  1 = write, 0 = read
- csr_addr  in  ADDR_W  [ADDR_W-1:2] counter index, [1:0] register: 0 LO, 1 HI, 2 CTRL, 3 STATUS
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data, valid when csr_rvalid
- csr_rvalid  out  1  read-response strobe
- ovf_irq  out  NUM_COUNTERS  per-counter overflow interrupt, level

## Operation
- Per-counter state: cnt[COUNTER_W], hi_shadow[COUNTER_W-32], ctrl (sel[EVENT_SEL_W-1:0] at bits [EVENT_SEL_W-1:0], irq_en bit 29, sat bit 30, en bit 31), ovf sticky.
- Increment condition: en & !freeze & events[sel], only when sel < NUM_EVENTS; otherwise the counter holds. Increment is exactly +1 per cycle.
- Overflow (cnt all-ones and increment): sat=0 -> cnt wraps to 0; sat=1 -> cnt holds all-ones. ovf is set in both cases.
- ovf_irq[i] = ovf[i] & irq_en[i], registered-state combinational; no extra delay.
- LO write: cnt[31:0] <= wdata. HI write: cnt[COUNTER_W-1:32] <= wdata[COUNTER_W-33:0]; excess bits are ignored.
- CTRL write: stores bits 31, 30, 29 and [EVENT_SEL_W-1:0]. Other bits read as 0.
- STATUS write: write-1-to-clear of ovf (bit 0). STATUS read: {31'b0, ovf}.
- LO read: returns cnt[31:0] and captures cnt[COUNTER_W-1:32] into hi_shadow in the same edge. HI read returns hi_shadow zero-extended to 32 bits, giving a tear-free 64-bit read sequence LO then HI.
- Access to a counter index >= NUM_COUNTERS: writes are ignored; reads return 0 with csr_rvalid.
- Reset values: cnt 0, hi_shadow 0, ctrl 0 (disabled), ovf 0, csr_rdata 0, csr_rvalid 0, ovf_irq 0.

## Timing
- Read latency is 1: csr_req & !csr_we in cycle N gives csr_rvalid=1 with csr_rdata in cycle N+1. The data is the counter value before the edge ending cycle N. Fully pipelined, one read per cycle.
- Writes take effect at the edge ending the request cycle. There is no write response.
- Write to a counter's LO or HI in the same cycle as its increment: the write wins and the increment is dropped.
- Overflow in the same cycle as a STATUS W1C to that counter: set wins and ovf stays 1.
- CTRL write enabling a counter: counting starts on events in the following cycle.
- freeze takes effect in the same cycle; register access is unaffected by freeze.
- rst_n asserted mid-access: all outputs go to their reset values immediately, and any pending read response is discarded.

## Test plan
- Reset, then read LO/HI/CTRL/STATUS of every counter -> all 0, csr_rvalid exactly one cycle after each request.
- CTRL[0]=0x80000003, events[3] high for 10 cycles with freeze high for 3 of them -> LO reads 7. Setting sel=NUM_EVENTS -> no further counting.
- COUNTER_W=33, write LO=0xFFFFFFFF and HI=1, sat=0, irq_en=1, one event -> cnt=0, ovf=1, ovf_irq asserted. STATUS write 1 -> ovf_irq deasserts next cycle.
- Same setup with sat=1 -> cnt holds 0x1_FFFFFFFF and ovf=1.
- Counter at 0x0_FFFFFFFF counting continuously: read LO, then HI two cycles later -> LO=0xFFFFFFFF, HI=0 (the shadow value, not the live 1).
- Write LO=5 in a cycle with an active event -> next LO read returns 5. Back-to-back reads of counters 0..3 -> four consecutive csr_rvalid pulses in order.
